cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 Parameter PRID_VALUE, default 32'h0000_2018, is the constant returned for register 15 (PRId).
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 A1  input  5  read register number (12 SR, 13 Cause, 14 EPC, 15 PRId).
REQ-005 A2  input  5  write register number for mtc0.
REQ-006 DIn  input  32  mtc0 write data.
REQ-007 We  input  1  mtc0 write enable.
REQ-008 PC  input  32  address of the instruction in the stage being interrupted.
REQ-009 BDIn  input  1  the instruction at PC sits in a branch delay slot.
REQ-010 ExcCodeIn  input  5  synchronous exception code; 5'd0 means no exception.
REQ-011 HWInt  input  6  hardware interrupt lines [7:2]; bit 2 is the timer IRQ.
REQ-012 EXLClr  input  1  eret is committing; clear EXL.
REQ-013 IntReq  output  1  take the exception/interrupt entry this cycle; the pipeline flushes and redirects to the handler.
REQ-014 EPC  output  32  current EPC value for eret.
REQ-015 DOut  output  32  mfc0 read data selected by A1.

Function
REQ-016 SR holds IM[15:10], EXL[1] and IE[0]; all other SR bits read 0.
REQ-017 Cause holds BD[31], IP[15:10] and ExcCode[6:2]; all other bits read 0.
REQ-018 IP[15:10] is loaded with HWInt every cycle, independent of every other event, and is visible on DOut the cycle after the lines change.
REQ-019 IntPend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL; this uses the live HWInt, not IP.
REQ-020 ExcPend = (ExcCodeIn != 0) & ~SR.EXL; exceptions raised while EXL=1 are ignored.
REQ-021 IntReq is combinational and equals IntPend | ExcPend.
REQ-022 On entry (IntReq=1) at posedge: EXL<=1; BD<=BDIn; EPC<={PC[31:2],2'b00} when BDIn=0, or {PC[31:2],2'b00}-4 when BDIn=1.
REQ-023 On entry, ExcCode<=0 if IntPend=1, otherwise ExcCode<=ExcCodeIn; an interrupt has priority over a simultaneous exception.
REQ-024 When We=1 and no entry occurs: A2=12 writes IM, EXL and IE from DIn[15:10], DIn[1] and DIn[0]; A2=14 writes EPC<={DIn[31:2],2'b00}.
REQ-025 Writes to any other A2 value (Cause, PRId, unimplemented) have no effect.
REQ-026 Entry and We in the same cycle: entry wins and the write is dropped entirely.
REQ-027 EXLClr=1 with no entry sets EXL<=0 at posedge. EXLClr with an entry: entry wins and EXL stays 1. EXLClr with an SR write: EXLClr overrides the written EXL bit; IM and IE are still written.
REQ-028 DOut: A1=12 gives SR, 13 gives Cause, 14 gives EPC, 15 gives PRID_VALUE, and any other value gives 32'h0. DOut is purely combinational.
REQ-029 EPC output always equals the EPC register.
REQ-030 Arithmetic is 32-bit modulo: a delay-slot PC of 0 gives EPC 32'hFFFF_FFFC.

Reset
REQ-031 On reset=1 at posedge: SR, Cause and EPC all become 0; reset overrides entry, We and EXLClr in the same cycle.
REQ-032 After reset, IntReq=0 until IE and IM are set by software, except for synchronous exceptions, since EXL=0.
REQ-033 The cycle after reset, IP reflects HWInt.

Verification
REQ-034 Reset, then We=1, A2=12, DIn=32'h0000_0401 (IM[10]=1, IE=1); HWInt=6'b000001, PC=32'h0000_3010, BDIn=0 -> IntReq=1 combinationally. After the edge: EPC=32'h0000_3010, EXL=1, ExcCode=0, IntReq=0.
REQ-035 Exception in a delay slot: ExcCodeIn=5'd12, PC=32'h0000_3008, BDIn=1, EXL=0 -> after the edge: EPC=32'h0000_3004, Cause=32'h8000_0030, SR.EXL=1.
REQ-036 Simultaneous: HWInt[2] enabled and pending, ExcCodeIn=5'd10, and We=1 with A2=14 -> ExcCode=0, EPC={PC[31:2],2'b00}, and the DIn write is dropped.
REQ-037 With EXL=1: ExcCodeIn=5'd4 -> IntReq=0 and no state change. Then EXLClr=1 -> EXL=0 next cycle, and IntReq reasserts if an enabled interrupt is still pending.
REQ-038 Reads: A1=15 -> PRID_VALUE; A1=7 -> 0; A1=13 with HWInt=6'b100001 (held one cycle) -> DOut[15:10]=6'b100001.
REQ-039 Reset asserted in the same cycle as an entry and a write -> all registers are 0 after the edge.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 status/cause/EPC block: decides exception/interrupt entry,
// records the return address, and serves mfc0/mtc0 accesses.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc_reg;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] pc_word;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        wr_sr;
  logic        wr_epc;

  // Interrupt decision uses the live lines, not the registered IP copy.
  assign int_pend   = (|(HWInt & im)) & ie & ~exl;
  assign exc_pend   = (ExcCodeIn != 5'd0) & ~exl;
  assign IntReq     = int_pend | exc_pend;

  assign pc_word    = {PC[31:2], 2'b00};
  assign sr_word    = {16'h0000, im, 8'h00, exl, ie};
  assign cause_word = {bd, 15'h0000, ip, 3'b000, exc_code, 2'b00};
  assign wr_sr      = We & (A2 == ADDR_SR);
  assign wr_epc     = We & (A2 == ADDR_EPC);
  assign EPC        = epc_reg;

  always_comb begin
    DOut = 32'h0000_0000;
    case (A1)
      ADDR_SR:    DOut = sr_word;
      ADDR_CAUSE: DOut = cause_word;
      ADDR_EPC:   DOut = epc_reg;
      ADDR_PRID:  DOut = PRID_VALUE;
      default:    DOut = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc_reg  <= 32'd0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        // Entry swallows any same-cycle mtc0 and eret.
        exl      <= 1'b1;
        bd       <= BDIn;
        epc_reg  <= BDIn ? (pc_word - 32'd4) : pc_word;
        exc_code <= int_pend ? 5'd0 : ExcCodeIn;
      end else begin
        if (wr_sr) begin
          im  <= DIn[15:10];
          ie  <= DIn[0];
          exl <= DIn[1] & ~EXLClr;
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (wr_epc) begin
          epc_reg <= {DIn[31:2], 2'b00};
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: word-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1, a2, exc_in;
  logic [31:0] din, pc;
  logic        we, bd_in, exl_clr;
  logic [5:0]  hw;
  logic        int_req;
  logic [31:0] epc, dout;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural view of the three registers as whole 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_unit #(.PRID_VALUE(32'h0000_2018)) dut (
    .clk(clk), .reset(rst), .A1(a1), .A2(a2), .DIn(din), .We(we),
    .PC(pc), .BDIn(bd_in), .ExcCodeIn(exc_in), .HWInt(hw), .EXLClr(exl_clr),
    .IntReq(int_req), .EPC(epc), .DOut(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_int_pend();
    return (|(hw & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_intreq();
    return m_int_pend() || ((exc_in != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_dout();
    case (a1)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_2018;
      default: return 32'h0;
    endcase
  endfunction

  // Compare outputs against the model, then advance model and DUT one clock.
  task automatic cyc();
    logic [31:0] n_sr, n_cause, n_epc;
    #1;
    chk("intreq", {31'd0, int_req}, {31'd0, m_intreq()});
    chk("dout", dout, m_dout());
    chk("epc_out", epc, m_epc);
    n_sr = m_sr; n_epc = m_epc;
    n_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
    if (rst) begin
      n_sr = 0; n_cause = 0; n_epc = 0;
    end else if (m_intreq()) begin
      n_sr = m_sr | 32'h2;
      n_cause = (n_cause & 32'h0000_FC00) | (bd_in ? 32'h8000_0000 : 32'h0)
                | (m_int_pend() ? 32'h0 : (32'(exc_in) << 2));
      n_epc = (pc & ~32'h3) - (bd_in ? 32'd4 : 32'd0);
    end else begin
      if (we && a2 == 5'd12) n_sr = din & 32'h0000_FC03;
      if (exl_clr) n_sr = n_sr & ~32'h2;
      if (we && a2 == 5'd14) n_epc = din & ~32'h3;
    end
    @(posedge clk);
    #1;
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
  endtask

  task automatic idle();
    rst = 0; we = 0; a2 = 0; din = 0; exc_in = 0; exl_clr = 0; bd_in = 0;
  endtask

  task automatic peek(input string name, input logic [4:0] addr, input logic [31:0] exp);
    a1 = addr; #1;
    chk(name, dout, exp);
  endtask

  initial begin
    idle(); a1 = 5'd12; hw = 0; pc = 0;
    m_sr = 'x; m_cause = 'x; m_epc = 'x;
    @(posedge clk); #1;
    rst = 1; #1; @(posedge clk); #1;
    m_sr = 0; m_cause = 0; m_epc = 0;
    rst = 0;
    peek("rst_sr", 5'd12, 32'h0); peek("rst_cause", 5'd13, 32'h0);
    chk("rst_intreq", {31'd0, int_req}, 32'h0);

    // Interrupt entry and EXL masking / eret
    we = 1; a2 = 5'd12; din = 32'h0000_0401; cyc(); idle();
    hw = 6'b000001; pc = 32'h0000_3010; #1;
    chk("int_comb", {31'd0, int_req}, 32'h1);
    cyc();
    chk("int_epc", epc, 32'h0000_3010);
    chk("int_intreq_after", {31'd0, int_req}, 32'h0);
    peek("int_sr", 5'd12, 32'h0000_0403); peek("int_cause", 5'd13, 32'h0000_0400);
    exc_in = 5'd4; cyc(); exc_in = 0;
    peek("exl_ignore_sr", 5'd12, 32'h0000_0403);
    chk("exl_ignore_epc", epc, 32'h0000_3010);
    exl_clr = 1; cyc(); exl_clr = 0;
    peek("eret_sr", 5'd12, 32'h0000_0401);
    chk("eret_reassert", {31'd0, int_req}, 32'h1);
    hw = 0;

    // Exception in a delay slot
    rst = 1; cyc(); idle();
    exc_in = 5'd12; pc = 32'h0000_3008; bd_in = 1; cyc(); idle();
    chk("ds_epc", epc, 32'h0000_3004);
    peek("ds_cause", 5'd13, 32'h8000_0030); peek("ds_sr", 5'd12, 32'h0000_0002);

    // Interrupt beats exception; mtc0 EPC dropped
    rst = 1; cyc(); idle();
    we = 1; a2 = 5'd12; din = 32'h0000_0401; cyc(); idle();
    hw = 6'b000001; exc_in = 5'd10; we = 1; a2 = 5'd14; din = 32'hDEAD_BEEF;
    pc = 32'h0000_4006; cyc(); idle();
    chk("sim_epc", epc, 32'h0000_4004);
    peek("sim_cause", 5'd13, 32'h0000_0400);

    // Read decode and IP tracking
    peek("prid", 5'd15, 32'h0000_2018); peek("unimpl", 5'd7, 32'h0);
    hw = 6'b100001; cyc();
    peek("ip_bits", 5'd13, 32'h0000_8400);

    // Delay-slot PC of zero wraps
    rst = 1; cyc(); idle(); hw = 0;
    exc_in = 5'd1; pc = 32'h0; bd_in = 1; cyc(); idle();
    chk("wrap_epc", epc, 32'hFFFF_FFFC);

    // Reset beats entry and write
    rst = 1; exc_in = 5'd5; hw = 6'b000001; we = 1; a2 = 5'd14; din = 32'hFFFF; cyc(); idle();
    chk("rst_all_epc", epc, 32'h0);
    peek("rst_all_sr", 5'd12, 32'h0); peek("rst_all_cause", 5'd13, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      hw      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      exc_in  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      we      = ($urandom_range(0, 2) == 0);
      a2      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      din     = $urandom;
      pc      = $urandom;
      bd_in   = $urandom_range(0, 1) == 1;
      exl_clr = ($urandom_range(0, 5) == 0);
      a1      = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
